// File: rtl/uart_byte_fifo.sv
// uart_byte_fifo: elastic byte buffer between a UART receiver and transmitter.
// Received bytes go into a circular FIFO and are replayed one at a time to the
// transmitter, paced by busy_tx.
// Optional feature macro: UART_BYTE_FIFO_OVERFLOW_EN (sticky overflow flag on drop).
module uart_byte_fifo #(
    parameter int DEPTH_LOG2    = 4,
    parameter int WAIT_BUSY_MAX = 4
) (
    input  logic                  clk,
    input  logic                  nRst,
    input  logic                  recieved,
    input  logic [7:0]            data_rx,
    input  logic                  busy_tx,
    output logic                  transmit,
    output logic [7:0]            data_tx,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  empty,
    output logic                  full,
    output logic                  overflow
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int WCW   = (WAIT_BUSY_MAX < 2) ? 1 : $clog2(WAIT_BUSY_MAX);

    localparam logic [DEPTH_LOG2:0]   CNT_ONE   = (DEPTH_LOG2 + 1)'(1);
    localparam logic [DEPTH_LOG2:0]   CNT_FULL  = (DEPTH_LOG2 + 1)'(DEPTH);
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE   = DEPTH_LOG2'(1);
    localparam logic [WCW-1:0]        WAIT_ONE  = WCW'(1);
    localparam logic [WCW-1:0]        WAIT_LAST = WCW'(WAIT_BUSY_MAX - 1);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_BUSY = 2'd1,
        WAIT_DONE = 2'd2
    } tx_state_e;

    logic [7:0]            mem_q [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_q;
    logic [DEPTH_LOG2-1:0] rd_q;
    logic [DEPTH_LOG2:0]   count_q;
    logic [DEPTH_LOG2:0]   count_d;
    logic                  empty_q;
    logic                  full_q;
    tx_state_e             state_q;
    logic [WCW-1:0]        wait_q;
    logic                  transmit_q;
    logic [7:0]            data_tx_q;
    logic                  pop;
    logic                  push;

    // A pop only happens from IDLE; a push into a full FIFO is allowed when
    // the same edge frees a slot.
    assign pop  = (state_q == IDLE) && !empty_q && !busy_tx;
    assign push = recieved && (!full_q || pop);

    // Next occupancy: push and pop together leave it unchanged.
    always_comb begin
        count_d = count_q;
        if (push && !pop)
            count_d = count_q + CNT_ONE;
        else if (pop && !push)
            count_d = count_q - CNT_ONE;
    end

    // Byte storage; contents need no reset since count gates every read.
    always_ff @(posedge clk) begin
        if (push)
            mem_q[wr_q] <= data_rx;
    end

    // Write pointer and registered occupancy flags, kept mutually consistent.
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            wr_q    <= '0;
            count_q <= '0;
            empty_q <= 1'b1;
            full_q  <= 1'b0;
        end else begin
            if (push)
                wr_q <= wr_q + PTR_ONE;
            count_q <= count_d;
            empty_q <= (count_d == '0);
            full_q  <= (count_d == CNT_FULL);
        end
    end

    // Transmit handshake FSM with registered strobe, data and read pointer.
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            state_q    <= IDLE;
            rd_q       <= '0;
            wait_q     <= '0;
            transmit_q <= 1'b0;
            data_tx_q  <= 8'h00;
        end else begin
            transmit_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (pop) begin
                        data_tx_q  <= mem_q[rd_q];
                        rd_q       <= rd_q + PTR_ONE;
                        transmit_q <= 1'b1;
                        wait_q     <= '0;
                        state_q    <= WAIT_BUSY;
                    end
                end
                WAIT_BUSY: begin
                    // Give up on busy after WAIT_BUSY_MAX cycles, counting the strobe cycle.
                    if (busy_tx)
                        state_q <= WAIT_DONE;
                    else if (wait_q == WAIT_LAST)
                        state_q <= IDLE;
                    else
                        wait_q <= wait_q + WAIT_ONE;
                end
                WAIT_DONE: begin
                    if (!busy_tx)
                        state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef UART_BYTE_FIFO_OVERFLOW_EN
    logic drop;
    logic overflow_q;

    assign drop = recieved && full_q && !pop;

    // Sticky drop flag, cleared only by reset.
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst)
            overflow_q <= 1'b0;
        else if (drop)
            overflow_q <= 1'b1;
    end

    assign overflow = overflow_q;
`else
    assign overflow = 1'b0;
`endif

    assign transmit = transmit_q;
    assign data_tx  = data_tx_q;
    assign count    = count_q;
    assign empty    = empty_q;
    assign full     = full_q;

endmodule
